prng_lfsr_gen: RTL
==================

# prng_lfsr_gen

Parametrised Galois LFSR pseudo-random generator with XNOR feedback. It replaces the fixed 16-bit free-running generator with a configurable one that adds:
- configurable width and tap mask
- multi-shift decimation per sample and a post-seed warm-up phase
- a valid/ready output handshake
- optional all-ones lock-up recovery

It sits between seed/control logic and any consumer of random words (test-pattern, dither, scrambler) on the clk_50m domain.

## Interface
- WIDTH, 16, LFSR state width (4..64)
- TAP_MASK, 16'h7070, bit i=1 → state bit i receives XNOR feedback (bit 0 ignored)
- OUT_W, 16, sample width, ≤ WIDTH
- STEPS, 1, LFSR shifts per delivered sample (1..255)
- WARMUP, 0, shifts discarded after each seed load (0..255)
- SAFE_SEED, 16'h0001, substitute state on lock-up (must not be all-ones)

Ports:
- clk_50m in 1 clock
- rst_n in 1 reset, asynchronous, active-low; clock clk_50m
- en in 1 shift enable
- load in 1 seed load strobe
- seed in WIDTH seed value
- rand_ready in 1 consumer ready
- rand_valid out 1 sample available
- rand_num out OUT_W sample
- lockup out 1 sticky lock-up flag
- busy out 1 high in WARMUP

## Operation
- Single step, s→n:
  - n[0] = s[W-1]
  - for i≥1: n[i] = TAP_MASK[i] ? ~(s[i-1]^s[W-1]) : s[i-1]
- All-ones is the only lock-up state; all-zeros is legal.
- FSM states:
  - WARMUP: while en, shift once per cycle. After WARMUP shifts → RUN; counter clears.
  - RUN: while en, shift once per cycle. On the STEPS-th shift, rand_num ← n[OUT_W-1:0] and rand_valid ← 1 in the same edge, counter clears → HOLD.
  - HOLD: state and rand_num frozen; en ignored. On rand_valid & rand_ready, rand_valid ← 0 → RUN.
- en=0 in WARMUP/RUN: pause, state and counter retained.
- load (highest priority, any state):
  - state ← seed, counter ← 0, rand_valid ← 0, lockup ← 0
  - next state is WARMUP if WARMUP>0, else RUN
  - rand_num keeps its old value
- Reset values: state 0, rand_num 0, rand_valid 0, lockup 0, busy 0, FSM RUN, counter 0.
- Counter width is $clog2(max(STEPS,WARMUP)+1). Counter is compared against STEPS-1 or WARMUP-1; no wrap beyond.

## Timing
- Best-case throughput: one sample per STEPS+1 cycles (STEPS shifts plus one handshake cycle).
- Latency from load (en held high) to first rand_valid: WARMUP+STEPS cycles.
- rand_valid, once high, stays high with rand_num stable until accepted.
- rand_ready while rand_valid=0 is ignored.
- load and rand_ready in the same cycle: load wins; the sample is dropped and not counted as accepted.
- Reset mid-operation clears everything asynchronously. The first edge after release behaves as RUN with counter 0.

## Configuration
- PRNG_LOCKUP_RECOVER_EN defined:
  - any registered state equal to all-ones (from load or otherwise) is replaced by SAFE_SEED on the next edge
  - lockup ← 1, held until the next load or reset
  - substitution takes the place of a shift that cycle
- PRNG_LOCKUP_RECOVER_EN undefined:
  - no detection; lockup tied 0
  - an all-ones seed produces all-ones samples forever

## Structure
- Package prng_pkg:
  - FSM state enum (WARMUP, RUN, HOLD)
  - default TAP_MASK constant 16'h7070
  - default SAFE_SEED constant
- Sub-module lfsr_step: purely combinational, parametrised WIDTH/TAP_MASK, computes n from s. Instantiated once.

## Test plan
- Reset, en=1, rand_ready=0, defaults → after 1 edge rand_valid=1, rand_num=0x7070. It holds 0x7070 for 10 cycles with no state advance.
- load seed=0x0001, en=1, STEPS=1 → next sample rand_num=0x7072; rand_ready=1 continuously gives one sample every 2 cycles.
- STEPS=4, WARMUP=3, load 0x0001 → busy high 3 cycles; first rand_valid 7 cycles after load and equals the 7-step value from the reference model.
- en toggled 0 for 5 cycles mid-RUN → sample delayed by exactly 5 cycles, value unchanged versus the en=1 run.
- load 0xFFFF:
  - with PRNG_LOCKUP_RECOVER_EN: state becomes 0x0001, lockup=1, cleared by the next load
  - without the macro: every rand_num=0xFFFF, lockup=0
- load and rand_ready asserted together while rand_valid=1 → rand_valid drops; the next sample derives from the new seed. Async reset in HOLD → all outputs 0 immediately.

Source files
------------

// File: rtl/prng_pkg.sv
// Shared types and default constants for the Galois LFSR random-word generator.
package prng_pkg;

  typedef enum logic [1:0] {
    ST_WARMUP,
    ST_RUN,
    ST_HOLD
  } prng_state_t;

  localparam logic [15:0] DEF_TAP_MASK  = 16'h7070;
  localparam logic [15:0] DEF_SAFE_SEED = 16'h0001;

endpackage

// File: rtl/lfsr_step.sv
// One combinational Galois LFSR step with XNOR feedback; bit 0 of TAP_MASK is ignored.
module lfsr_step
  import prng_pkg::*;
#(
  parameter int unsigned           WIDTH    = 16,
  parameter logic [WIDTH-1:0]      TAP_MASK = WIDTH'(DEF_TAP_MASK)
) (
  input  logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] n
);

  always_comb begin
    n    = '0;
    n[0] = s[WIDTH-1];
    for (int unsigned i = 1; i < WIDTH; i++) begin
      n[i] = TAP_MASK[i] ? ~(s[i-1] ^ s[WIDTH-1]) : s[i-1];
    end
  end

endmodule

// File: rtl/prng_lfsr_gen.sv
// Configurable LFSR generator: warm-up, STEPS-shift decimation, valid/ready output.
// Optional all-ones recovery is built when PRNG_LOCKUP_RECOVER_EN is defined.
module prng_lfsr_gen
  import prng_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAP_MASK  = WIDTH'(DEF_TAP_MASK),
  parameter int unsigned      OUT_W     = 16,
  parameter int unsigned      STEPS     = 1,
  parameter int unsigned      WARMUP    = 0,
  parameter logic [WIDTH-1:0] SAFE_SEED = WIDTH'(DEF_SAFE_SEED)
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             rand_ready,
  output logic             rand_valid,
  output logic [OUT_W-1:0] rand_num,
  output logic             lockup,
  output logic             busy
);

  localparam int unsigned CNT_MAX = (STEPS > WARMUP) ? STEPS : WARMUP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STEPS_LAST = CNT_W'(STEPS - 1);
  localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam prng_state_t      LOAD_NEXT  = (WARMUP > 0) ? ST_WARMUP : ST_RUN;

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_n;
  logic [CNT_W-1:0] cnt_q;
  prng_state_t      fsm_q;

  lfsr_step #(
    .WIDTH    (WIDTH),
    .TAP_MASK (TAP_MASK)
  ) u_step (
    .s (lfsr_q),
    .n (lfsr_n)
  );

`ifndef PRNG_LOCKUP_RECOVER_EN
  assign lockup = 1'b0;
`endif

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q     <= '0;
      cnt_q      <= '0;
      fsm_q      <= ST_RUN;
      rand_num   <= '0;
      rand_valid <= 1'b0;
      busy       <= 1'b0;
`ifdef PRNG_LOCKUP_RECOVER_EN
      lockup     <= 1'b0;
`endif
    end else if (load) begin
      lfsr_q     <= seed;
      cnt_q      <= '0;
      rand_valid <= 1'b0;
      fsm_q      <= LOAD_NEXT;
      busy       <= (WARMUP > 0);
`ifdef PRNG_LOCKUP_RECOVER_EN
      lockup     <= 1'b0;
    end else if (&lfsr_q) begin
      // Substitution replaces this cycle's shift; counter and FSM stay put.
      lfsr_q <= SAFE_SEED;
      lockup <= 1'b1;
`endif
    end else begin
      case (fsm_q)
        ST_WARMUP: if (en) begin
          lfsr_q <= lfsr_n;
          if (cnt_q == WARM_LAST) begin
            cnt_q <= '0;
            fsm_q <= ST_RUN;
            busy  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: if (en) begin
          lfsr_q <= lfsr_n;
          if (cnt_q == STEPS_LAST) begin
            cnt_q      <= '0;
            rand_num   <= lfsr_n[OUT_W-1:0];
            rand_valid <= 1'b1;
            fsm_q      <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_HOLD: if (rand_ready) begin
          rand_valid <= 1'b0;
          fsm_q      <= ST_RUN;
        end
        default: fsm_q <= ST_RUN;
      endcase
    end
  end

endmodule
